// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: state encoding and sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH     = 32;
    localparam int DIV_LAST_ITER = DIV_WIDTH - 1;

endpackage

// File: rtl/div_iter_unit_if.sv
// Operand/result bundle between the multdiv front-end and the iterative divider.
interface div_iter_unit_if
    import div_pkg::*;
    #(parameter int WIDTH = DIV_WIDTH);

    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: synchronous up-count with clear/enable,
// flags the final quotient-bit iteration.
module div_iter_counter
    import div_pkg::*;
    #(
        parameter int CNT_W = 6,
        parameter int LAST  = DIV_LAST_ITER
    ) (
        input  logic clock,
        input  logic reset,
        input  logic clr,
        input  logic en,
        output logic last
    );

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(LAST));

endmodule

// File: rtl/div_iter_unit.sv
// Iterative signed restoring divider: one quotient bit per clock on magnitudes,
// sign fix-up in a final cycle, one-cycle result-ready pulse.
module div_iter_unit
    import div_pkg::*;
    #(
        parameter int WIDTH = DIV_WIDTH,
        parameter int CNT_W = 6
    ) (
        input  logic            clock,
        input  logic            reset,
        div_iter_unit_if.slave  bus
    );

    div_state_t       state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] b_mag;
    logic             sign_q;
    logic             sign_r;
    logic             divzero;
    logic             cnt_last;

    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH:0]   shifted_r;
    logic [WIDTH:0]   trial;

    // Magnitude of INT_MIN wraps to itself, which is the correct unsigned value.
    assign a_mag_in  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign b_mag_in  = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // Partial remainder is always below |B|, so WIDTH bits hold it between steps;
    // the extra bit only exists during the shift/trial subtract.
    assign shifted_r = {r, q[WIDTH-1]};
    assign trial     = shifted_r - {1'b0, b_mag};

    div_iter_counter #(
        .CNT_W (CNT_W),
        .LAST  (WIDTH - 1)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (bus.ctrl_DIV),
        .en    (state == ITER),
        .last  (cnt_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            q                  <= '0;
            r                  <= '0;
            b_mag              <= '0;
            sign_q             <= 1'b0;
            sign_r             <= 1'b0;
            divzero            <= 1'b0;
            bus.data_result    <= '0;
            bus.data_remainder <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            // A start in any state aborts whatever is in flight.
            state              <= ITER;
            q                  <= a_mag_in;
            r                  <= '0;
            b_mag              <= b_mag_in;
            sign_q             <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            sign_r             <= bus.data_operandA[WIDTH-1];
            divzero            <= (bus.data_operandB == '0);
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b1;
        end else begin
            case (state)
                ITER: begin
                    if (!trial[WIDTH]) begin
                        r <= trial[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        r <= shifted_r[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_last) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (divzero) begin
                        bus.data_result    <= '0;
                        bus.data_remainder <= '0;
                    end else begin
                        bus.data_result    <= sign_q ? -q : q;
                        bus.data_remainder <= sign_r ? -r : r;
                    end
                    bus.data_exception <= divzero;
                    bus.data_resultRDY <= 1'b1;
                    bus.busy           <= 1'b0;
                    state              <= DONE;
                end
                DONE: begin
                    bus.data_resultRDY <= 1'b0;
                    state              <= IDLE;
                end
                default: begin
                    bus.data_resultRDY <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit: signs, divide-by-zero, overflow,
// abort-by-restart and mid-operation reset.
module tb_div_iter_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   edges;
    int   seen;

    div_iter_unit_if #(.WIDTH(32)) bus ();

    div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
    endtask

    // Edges counted from the start edge until data_resultRDY is seen; -1 on timeout.
    task automatic wait_rdy(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ee);
        int n;
        start(a, b);
        check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
        wait_rdy(n);
        check({tag, "_latency"}, n, 32'd33);
        check({tag, "_busy_rdy"}, 32'(bus.busy), 32'd0);
        check({tag, "_quot"}, bus.data_result, eq);
        check({tag, "_rem"}, bus.data_remainder, er);
        check({tag, "_exc"}, 32'(bus.data_exception), 32'(ee));
        @(posedge clock);
        #1;
        check({tag, "_rdy_drop"}, 32'(bus.data_resultRDY), 32'd0);
    endtask

    initial begin
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_quot", bus.data_result, 32'd0);
        check("rst_rem", bus.data_remainder, 32'd0);
        check("rst_exc", 32'(bus.data_exception), 32'd0);
        check("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        do_div("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        do_div("n100_7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        do_div("p100_n7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
        do_div("n100_n7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
        do_div("div0", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
        do_div("p9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        do_div("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        do_div("min_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
        do_div("small_big", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0);

        // Restart at E10 with new operands: exactly one pulse, 33 edges after the restart.
        start(32'd1000, 32'd10);
        repeat (9) @(posedge clock);
        start(32'd50, 32'd5);
        wait_rdy(edges);
        check("abort_latency", edges, 32'd33);
        check("abort_quot", bus.data_result, 32'd10);
        check("abort_rem", bus.data_remainder, 32'd0);
        @(posedge clock);
        #1;
        check("abort_rdy_drop", 32'(bus.data_resultRDY), 32'd0);

        // Reset at E15 clears everything and suppresses the pending result.
        start(32'd77, 32'd3);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_quot", bus.data_result, 32'd0);
        check("mid_rst_rem", bus.data_remainder, 32'd0);
        check("mid_rst_exc", 32'(bus.data_exception), 32'd0);
        check("mid_rst_rdy", 32'(bus.data_resultRDY), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) seen++;
        end
        check("mid_rst_no_rdy", seen, 32'd0);
        do_div("p77_3", 32'd77, 32'd3, 32'd25, 32'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
